sha256_padder: RTL and testbench

Upstream message formatter for the SHA-256 engine. Accepts a message as a stream of big-endian 32-bit words with a valid/ready handshake. Applies FIPS 180-4 padding: 0x80 marker, zero fill, 64-bit bit-length field. Emits complete 512-bit blocks, each with a last-block flag, to the `hash_output` / `w_i_update` compression pipeline.

---
 rtl/sha256_pkg.sv | 44 ++++
 rtl/sha256_pad_word.sv | 44 ++++
 rtl/sha256_padder.sv | 181 ++++++++++++++++++
 tb/tb_sha256_padder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_pkg
//  Brief    : Shared types and constants for the SHA-256 padder and core.
//  Revision : 1.0
// ============================================================================
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_OUT  = 2'd1,
        ST_PAD2 = 2'd2
    } pad_state_t;

    localparam int         SHA256_BLK_BITS = 512;
    localparam int         SHA256_LEN_BITS = 64;
    localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

    localparam logic [31:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] SHA256_H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage
`default_nettype wire

// File: rtl/sha256_pad_word.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_pad_word
//  Brief    : Masks the final message word to nbytes and appends the 0x80 marker.
//  Revision : 1.0
// ============================================================================
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  nbytes,
    output logic [31:0] padded,
    output logic        marker_fit
);

    always_comb begin
        padded     = word;
        marker_fit = 1'b0;
        case (nbytes)
            3'd0: begin
                padded     = {SHA256_PAD_BYTE, 24'h0};
                marker_fit = 1'b1;
            end
            3'd1: begin
                padded     = {word[31:24], SHA256_PAD_BYTE, 16'h0};
                marker_fit = 1'b1;
            end
            3'd2: begin
                padded     = {word[31:16], SHA256_PAD_BYTE, 8'h0};
                marker_fit = 1'b1;
            end
            3'd3: begin
                padded     = {word[31:8], SHA256_PAD_BYTE};
                marker_fit = 1'b1;
            end
            default: begin
                padded     = word;
                marker_fit = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_padder
//  Brief    : FIPS 180-4 message padder producing 512-bit blocks for the core.
//             Define SHA256_PADDER_FIRST_EN to drive blk_first.
//  Revision : 1.0
// ============================================================================
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic [2:0]                 in_nbytes,
    output logic                       in_ready,
    output logic [SHA256_BLK_BITS-1:0] blk_data,
    output logic                       blk_valid,
    output logic                       blk_last,
    output logic                       blk_first,
    input  logic                       blk_ready
);

    localparam int CNT_W = LEN_W - 3;

    pad_state_t                 r_state;
    pad_state_t                 w_state_nxt;
    logic [31:0]                r_word [0:15];
    logic [3:0]                 r_widx;
    logic [CNT_W-1:0]           r_byte_cnt;
    logic                       r_pend_last;
    logic                       r_pend_pad2;
    logic                       r_marker_done;

    logic                       w_accept;
    logic                       w_hs;
    logic [3:0]                 w_widx_inc;
    logic [CNT_W-1:0]           w_beat_bytes;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic [6:0]                 w_blk_bytes;
    logic [SHA256_LEN_BITS-1:0] w_len_nxt;
    logic [SHA256_LEN_BITS-1:0] w_len_cur;
    logic [31:0]                w_pad_word;
    logic                       w_marker_fit;

    sha256_pad_word u_pad_word (
        .word       (in_data),
        .nbytes     (in_nbytes),
        .padded     (w_pad_word),
        .marker_fit (w_marker_fit)
    );

    assign w_widx_inc   = r_widx + 4'd1;
    assign w_beat_bytes = in_last ? CNT_W'(in_nbytes) : CNT_W'(4);
    assign w_cnt_nxt    = r_byte_cnt + w_beat_bytes;
    // Bytes held in the current block; 64 must stay distinct from 0 here.
    assign w_blk_bytes  = {1'b0, r_widx, 2'b00} + {4'b0000, in_nbytes};
    assign w_len_nxt    = SHA256_LEN_BITS'({w_cnt_nxt, 3'b000});
    assign w_len_cur    = SHA256_LEN_BITS'({r_byte_cnt, 3'b000});

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pack
            assign blk_data[SHA256_BLK_BITS-1-32*gi -: 32] = r_word[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        blk_valid   = 1'b0;
        blk_last    = 1'b0;
        w_accept    = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            ST_FILL: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && (in_last || (r_widx == 4'd15))) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                blk_valid = 1'b1;
                blk_last  = r_pend_last;
                w_hs      = blk_ready;
                if (blk_ready) begin
                    w_state_nxt = r_pend_pad2 ? ST_PAD2 : ST_FILL;
                end
            end
            ST_PAD2: begin
                w_state_nxt = ST_OUT;
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_word[i] <= '0;
            r_widx        <= '0;
            r_byte_cnt    <= '0;
            r_pend_last   <= 1'b0;
            r_pend_pad2   <= 1'b0;
            r_marker_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_byte_cnt <= w_cnt_nxt;
                r_widx     <= w_widx_inc;
                if (!in_last) begin
                    r_word[r_widx] <= in_data;
                end else begin
                    r_word[r_widx] <= w_pad_word;
                    if (!w_marker_fit && (r_widx != 4'd15)) begin
                        r_word[w_widx_inc] <= {SHA256_PAD_BYTE, 24'h0};
                    end
                    if (w_blk_bytes <= 7'd55) begin
                        r_word[14]  <= w_len_nxt[63:32];
                        r_word[15]  <= w_len_nxt[31:0];
                        r_pend_last <= 1'b1;
                    end else begin
                        r_pend_pad2   <= 1'b1;
                        r_marker_done <= w_marker_fit || (r_widx != 4'd15);
                    end
                end
            end
            if (w_hs) begin
                for (int i = 0; i < 16; i++) r_word[i] <= '0;
                r_widx      <= '0;
                r_pend_last <= 1'b0;
                if (!r_pend_pad2) begin
                    r_marker_done <= 1'b0;
                end
                if (r_pend_last) begin
                    r_byte_cnt <= '0;
                end
            end
            // Trailing block: marker only if the data block had no room for it.
            if (r_state == ST_PAD2) begin
                r_word[0]     <= r_marker_done ? 32'h0 : {SHA256_PAD_BYTE, 24'h0};
                r_word[14]    <= w_len_cur[63:32];
                r_word[15]    <= w_len_cur[31:0];
                r_pend_last   <= 1'b1;
                r_pend_pad2   <= 1'b0;
                r_marker_done <= 1'b0;
            end
        end
    end

`ifdef SHA256_PADDER_FIRST_EN
    logic r_first_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first_pend <= 1'b1;
        end else if (w_hs) begin
            r_first_pend <= r_pend_last;
        end
    end

    assign blk_first = blk_valid & r_first_pend;
`else
    assign blk_first = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_padder
//  Brief    : Self-checking bench for sha256_padder against a byte-level padding model.
//  Revision : 1.0
// ============================================================================
module tb_sha256_padder;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic         first;
    } blk_t;

    typedef struct {
        string        name;
        int           len;
        int           nblk;
        logic [63:0]  blk0_low;
        logic [511:0] last_blk;
    } vec_t;

`ifdef SHA256_PADDER_FIRST_EN
    localparam bit FIRST_EN = 1'b1;
`else
    localparam bit FIRST_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [2:0]   in_nbytes = '0;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_first;
    logic         blk_ready = 1'b0;

    int           checks = 0;
    int           errors = 0;
    int           ready_mode = 0;
    blk_t         exp_q[$];
    blk_t         rx_q[$];
    logic [7:0]   msg[$];
    int           rx_cnt;
    logic [511:0] first_rx;
    logic [511:0] last_rx;

    always #5 clk = ~clk;

    sha256_padder dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .blk_first (blk_first),
        .blk_ready (blk_ready)
    );

    task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Reference: whole-message padding, then split into 64-byte blocks.
    task automatic model_push();
        logic [7:0]  p[$];
        logic [63:0] bl;
        int          nb;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            blk_t e;
            e.data = '0;
            for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = p[64*b+j];
            e.last  = (b == nb - 1);
            e.first = FIRST_EN && (b == 0);
            exp_q.push_back(e);
        end
    endtask

    // Consumer: random or forced blk_ready, capture on handshake, hold check.
    initial begin
        logic [511:0] held;
        logic         held_v;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held_v    = 1'b0;
                blk_ready = 1'b0;
            end else begin
                if (held_v) begin
                    chk1("hold_valid", blk_valid, 1'b1);
                    chkw("hold_data", blk_data, held);
                    chk1("hold_in_ready", in_ready, 1'b0);
                end
                case (ready_mode)
                    0:       blk_ready = ($urandom_range(0, 3) != 0);
                    1:       blk_ready = 1'b0;
                    default: blk_ready = 1'b1;
                endcase
                if (blk_valid && blk_ready) rx_q.push_back('{blk_data, blk_last, blk_first});
                held_v = blk_valid && !blk_ready;
                held   = blk_data;
            end
        end
    end

    function automatic logic [31:0] beat_word(input int k, input int nvalid);
        logic [31:0] w;
        w = $urandom;
        for (int j = 0; j < nvalid; j++) w[31-8*j -: 8] = msg[4*k+j];
        return w;
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t;
        t = 0;
        @(negedge clk);
        repeat ($urandom_range(0, 1)) @(negedge clk);
        in_data   = d;
        in_last   = last;
        in_nbytes = nb;
        in_valid  = 1'b1;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: got timeout want in_ready");
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input bit zero_term);
        int n, nfull, rem, nl;
        n     = msg.size();
        nfull = n / 4;
        rem   = n % 4;
        if (n == 0) begin
            send_beat($urandom, 1'b1, 3'd0);
        end else begin
            nl = (rem == 0 && !zero_term) ? nfull - 1 : nfull;
            for (int k = 0; k < nl; k++) send_beat(beat_word(k, 4), 1'b0, 3'($urandom_range(0, 7)));
            if (rem != 0)      send_beat(beat_word(nfull, rem), 1'b1, 3'(rem));
            else if (zero_term) send_beat($urandom, 1'b1, 3'd0);
            else               send_beat(beat_word(nfull - 1, 4), 1'b1, 3'd4);
        end
    endtask

    task automatic drain(input string tag);
        int   t, idx;
        blk_t e, r;
        t = 0;
        while (rx_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        rx_cnt = rx_q.size();
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d want %0d", tag, rx_q.size(), exp_q.size());
        end
        idx = 0;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            chkw({tag, "_data"}, r.data, e.data);
            chk1({tag, "_last"}, r.last, e.last);
            chk1({tag, "_first"}, r.first, e.first);
            if (idx == 0) first_rx = r.data;
            last_rx = r.data;
            idx++;
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    initial begin
        vec_t vecs[4];
        logic [511:0] abc_blk;
        logic [511:0] held;
        int t;

        abc_blk = {32'h61626380, 416'h0, 64'h18};
        vecs[0] = '{"abc",   3,  1, 64'h18,               abc_blk};
        vecs[1] = '{"empty", 0,  1, 64'h0,                {32'h80000000, 480'h0}};
        vecs[2] = '{"len56", 56, 2, 64'h8000000000000000, {448'h0, 64'h1C0}};
        vecs[3] = '{"len64", 64, 2, 64'h65666768696a6b6c, {32'h80000000, 416'h0, 64'h200}};

        repeat (3) @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_blk_valid", blk_valid, 1'b0);
        chk1("rst_blk_last", blk_last, 1'b0);
        chk1("rst_blk_first", blk_first, 1'b0);
        chkw("rst_blk_data", blk_data, '0);
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            msg.delete();
            for (int i = 0; i < vecs[v].len; i++) msg.push_back(8'h61 + 8'(i % 26));
            model_push();
            send_msg(1'b0);
            drain(vecs[v].name);
            chkw({vecs[v].name, "_nblk"}, 512'(rx_cnt), 512'(vecs[v].nblk));
            chkw({vecs[v].name, "_blk0_low"}, 512'(first_rx[63:0]), 512'(vecs[v].blk0_low));
            chkw({vecs[v].name, "_lastblk"}, last_rx, vecs[v].last_blk);
        end

        // Backpressure followed by a back-to-back one-byte message.
        msg = '{8'h61, 8'h62, 8'h63};
        model_push();
        msg = '{8'h61};
        model_push();
        ready_mode = 1;
        fork
            begin
                msg = '{8'h61, 8'h62, 8'h63};
                send_msg(1'b0);
                msg = '{8'h61};
                send_msg(1'b0);
            end
        join_none
        t = 0;
        while (!blk_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk1("bp_valid_seen", blk_valid, 1'b1);
        held = blk_data;
        repeat (5) begin
            @(negedge clk);
            chkw("bp_data", blk_data, held);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        chkw("bp_abc", held, abc_blk);
        ready_mode = 0;
        wait fork;
        drain("bp");
        chkw("bp_a_len", 512'(last_rx[63:0]), 512'(64'h8));

        // Reset in the middle of a message.
        msg.delete();
        for (int i = 0; i < 40; i++) msg.push_back(8'($urandom));
        for (int k = 0; k < 7; k++) send_beat(beat_word(k, 4), 1'b0, 3'd4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk1("midrst_blk_valid", blk_valid, 1'b0);
        reset = 1'b0;
        rx_q.delete();
        msg = '{8'h61, 8'h62, 8'h63};
        model_push();
        send_msg(1'b0);
        drain("midrst");
        chkw("midrst_nblk", 512'(rx_cnt), 512'(1));
        chkw("midrst_blk", last_rx, abc_blk);

        // Randomized messages against the byte-level model.
        for (int m = 0; m < 25; m++) begin
            int len;
            len = $urandom_range(0, 140);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            model_push();
            send_msg(1'($urandom_range(0, 1)));
            drain("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
